bus_arbiter: RTL and testbench

//  Sequences the shared 17-bit RAM/IO bus between the 6502 CPU and SPI-initiated (Pi) accesses.

---
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : 16-slot TDM sequencer sharing the RAM/IO bus between the CPU
//            (slots 0-7) and one Pi access window (slots 8-11) per frame.
// Revision : 1.0
// ============================================================================
module bus_arbiter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pi_pending,
    input  logic [16:0] pi_addr,
    input  logic [7:0]  pi_data_out,
    input  logic        pi_rw_b,
    output logic        pi_done,
    output logic [7:0]  pi_data_in,
    output logic        cpu_be,
    output logic        cpu_clk_en,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_data_out,
    output logic        ram_data_oe,
    input  logic [7:0]  ram_data_in,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    localparam logic [3:0] C_SLOT_GRANT = 4'd7;
    localparam logic [3:0] C_SLOT_READ  = 4'd10;
    localparam logic [3:0] C_SLOT_DONE  = 4'd11;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_slot;
    logic                   r_grant;
    logic                   r_rw;

    logic                   w_pend_s;
    logic [3:0]             w_slot_nxt;
    logic                   w_enter_pi;
    logic                   w_grant_nxt;
    logic                   w_rw_nxt;
    logic                   w_strobe_slot;
    logic                   w_window_slot;

    assign w_pend_s = r_sync[SYNC_STAGES-1];

    // Outputs are registered, so every decode looks at the slot being entered.
    always_comb begin
        w_slot_nxt    = r_slot + 4'd1;
        w_enter_pi    = (r_slot == C_SLOT_GRANT);
        w_grant_nxt   = r_grant;
        w_rw_nxt      = r_rw;
        if (w_enter_pi) begin
            w_grant_nxt = w_pend_s && !pi_done;
            if (w_grant_nxt) begin
                w_rw_nxt = pi_rw_b;
            end
        end else if (r_slot == C_SLOT_DONE) begin
            w_grant_nxt = 1'b0;
        end
        w_strobe_slot = (w_slot_nxt == 4'd9) || (w_slot_nxt == 4'd10);
        w_window_slot = (w_slot_nxt[3:2] == 2'b10);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync       <= '0;
            r_slot       <= 4'd0;
            r_grant      <= 1'b0;
            r_rw         <= 1'b0;
            pi_done      <= 1'b0;
            pi_data_in   <= 8'd0;
            cpu_be       <= 1'b1;
            cpu_clk_en   <= 1'b0;
            ram_addr     <= 17'd0;
            ram_data_out <= 8'd0;
            ram_data_oe  <= 1'b0;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], pi_pending};
            r_slot      <= w_slot_nxt;
            r_grant     <= w_grant_nxt;
            r_rw        <= w_rw_nxt;

            cpu_be      <= !w_slot_nxt[3];
            cpu_clk_en  <= (w_slot_nxt == 4'd7);
            ram_oe_n    <= !(w_grant_nxt && w_rw_nxt && w_strobe_slot);
            ram_we_n    <= !(w_grant_nxt && !w_rw_nxt && w_strobe_slot);
            ram_data_oe <= w_grant_nxt && !w_rw_nxt && w_window_slot;

            if (w_enter_pi && w_grant_nxt) begin
                ram_addr     <= pi_addr;
                ram_data_out <= pi_data_out;
            end

            if ((r_slot == C_SLOT_READ) && r_grant && r_rw) begin
                pi_data_in <= ram_data_in;
            end

            // Completion wins over the clear so a withdrawn request still sees done.
            if ((r_slot == C_SLOT_DONE) && r_grant) begin
                pi_done <= 1'b1;
            end else if (!w_pend_s) begin
                pi_done <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed and randomized checks of bus_arbiter against a
//            slot-timeline reference model.
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pi_pending;
    logic [16:0] pi_addr;
    logic [7:0]  pi_data_out;
    logic        pi_rw_b;
    logic        pi_done;
    logic [7:0]  pi_data_in;
    logic        cpu_be;
    logic        cpu_clk_en;
    logic [16:0] ram_addr;
    logic [7:0]  ram_data_out;
    logic        ram_data_oe;
    logic [7:0]  ram_data_in;
    logic        ram_oe_n;
    logic        ram_we_n;

    bus_arbiter #(.SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .reset        (reset),
        .pi_pending   (pi_pending),
        .pi_addr      (pi_addr),
        .pi_data_out  (pi_data_out),
        .pi_rw_b      (pi_rw_b),
        .pi_done      (pi_done),
        .pi_data_in   (pi_data_in),
        .cpu_be       (cpu_be),
        .cpu_clk_en   (cpu_clk_en),
        .ram_addr     (ram_addr),
        .ram_data_out (ram_data_out),
        .ram_data_oe  (ram_data_oe),
        .ram_data_in  (ram_data_in),
        .ram_oe_n     (ram_oe_n),
        .ram_we_n     (ram_we_n)
    );

    always #5 clk = ~clk;

    // Reference model: time since reset, pending history, current access.
    int        m_t;
    bit        m_hist [SYNC];
    bit        m_grant;
    bit        m_done;
    bit        m_rw;
    bit [16:0] m_addr;
    bit [7:0]  m_wdata;
    bit [7:0]  m_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    int we_low_clks, oe_low_clks, we_pulses, clk_en_cnt;
    bit last_we_n = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        we_low_clks = 0;
        oe_low_clks = 0;
        we_pulses   = 0;
        clk_en_cnt  = 0;
    endtask

    task automatic step();
        bit ps, g_old, d_old;
        int prev, s;
        @(posedge clk);
        if (reset) begin
            m_t = 0; m_grant = 0; m_done = 0; m_rw = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0;
            for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
        end else begin
            ps    = m_hist[SYNC-1];
            prev  = m_t % 16;
            g_old = m_grant;
            d_old = m_done;
            for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = pi_pending;
            m_t++;
            if (prev == 7) begin
                m_grant = ps && !d_old;
                if (m_grant) begin
                    m_addr = pi_addr; m_wdata = pi_data_out; m_rw = pi_rw_b;
                end
            end
            if (prev == 10 && g_old && m_rw) m_rdata = ram_data_in;
            if (prev == 11 && g_old) begin
                m_done = 1; m_grant = 0;
            end else if (!ps) begin
                m_done = 0;
            end
        end
        #1;
        s = m_t % 16;
        chk("cpu_be",       cpu_be,       s < 8);
        chk("cpu_clk_en",   cpu_clk_en,   s == 7);
        chk("ram_oe_n",     ram_oe_n,     !(m_grant && m_rw && (s == 9 || s == 10)));
        chk("ram_we_n",     ram_we_n,     !(m_grant && !m_rw && (s == 9 || s == 10)));
        chk("ram_data_oe",  ram_data_oe,  m_grant && !m_rw && s >= 8 && s <= 11);
        chk("pi_done",      pi_done,      m_done);
        chk("pi_data_in",   pi_data_in,   m_rdata);
        chk("ram_addr",     ram_addr,     m_addr);
        chk("ram_data_out", ram_data_out, m_wdata);
        if (!ram_we_n) we_low_clks++;
        if (!ram_oe_n) oe_low_clks++;
        if (cpu_clk_en) clk_en_cnt++;
        if (last_we_n && !ram_we_n) we_pulses++;
        last_we_n = ram_we_n;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic to_slot(input int s);
        do step(); while ((m_t % 16) != s);
    endtask

    task automatic request(input logic [16:0] a, input logic [7:0] d, input logic rw);
        pi_addr = a; pi_data_out = d; pi_rw_b = rw; pi_pending = 1'b1;
    endtask

    initial begin
        reset = 1'b1; pi_pending = 1'b0; pi_addr = '0; pi_data_out = '0;
        pi_rw_b = 1'b1; ram_data_in = '0;
        clr_counts();
        #1;
        run(3);
        reset = 1'b0;

        // 1: write
        request(17'h15581, 8'h7e, 1'b0);
        clr_counts();
        to_slot(12);
        chk("t1_done",      pi_done,      1);
        chk("t1_addr",      ram_addr,     17'h15581);
        chk("t1_wdata",     ram_data_out, 8'h7e);
        chk("t1_we_clks",   we_low_clks,  2);
        pi_pending = 1'b0;
        run(SYNC + 1);
        chk("t1_done_clr",  pi_done,      0);

        // 2: read
        to_slot(0);
        request(17'h08000, 8'h00, 1'b1);
        ram_data_in = 8'ha5;
        clr_counts();
        to_slot(12);
        chk("t2_rdata",     pi_data_in,   8'ha5);
        chk("t2_done",      pi_done,      1);
        chk("t2_oe_clks",   oe_low_clks,  2);
        chk("t2_we_clks",   we_low_clks,  0);
        pi_pending = 1'b0;
        run(SYNC + 1);

        // 3: late request waits for the next frame
        to_slot(9);
        request(17'h01234, 8'h3c, 1'b0);
        clr_counts();
        to_slot(0);
        chk("t3_no_strobe", we_low_clks,  0);
        to_slot(12);
        chk("t3_we_clks",   we_low_clks,  2);
        chk("t3_done",      pi_done,      1);
        pi_pending = 1'b0;
        run(SYNC + 1);

        // 4: pending held long after done
        to_slot(0);
        request(17'h0aaaa, 8'h55, 1'b0);
        clr_counts();
        run(64);
        chk("t4_one_pulse", we_pulses,    1);
        chk("t4_done_held", pi_done,      1);
        pi_pending = 1'b0;
        run(4);
        chk("t4_done_clr",  pi_done,      0);
        pi_pending = 1'b1;
        clr_counts();
        to_slot(12);
        chk("t4_second",    we_pulses,    1);
        pi_pending = 1'b0;
        run(SYNC + 1);

        // 5: reset in the middle of a write
        to_slot(0);
        request(17'h1f00f, 8'h99, 1'b0);
        to_slot(9);
        chk("t5_we_active", ram_we_n,     0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_we_off",    ram_we_n,     1);
        chk("t5_no_done",   pi_done,      0);
        clr_counts();
        run(7);
        chk("t5_slot0",     cpu_clk_en,   1);
        to_slot(12);
        chk("t5_rerun",     we_low_clks,  2);
        chk("t5_done",      pi_done,      1);
        pi_pending = 1'b0;
        run(SYNC + 1);

        // 6: idle frames
        to_slot(0);
        clr_counts();
        run(64);
        chk("t6_clk_en",    clk_en_cnt,   4);
        chk("t6_we",        we_low_clks,  0);
        chk("t6_oe",        oe_low_clks,  0);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 800; k++) begin
            ram_data_in = 8'($urandom);
            if (!pi_pending) begin
                if ($urandom_range(0, 9) == 0)
                    request(17'($urandom), 8'($urandom), 1'($urandom));
            end else if (pi_done || $urandom_range(0, 60) == 0) begin
                if ($urandom_range(0, 3) == 0) pi_pending = 1'b0;
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
